// File: rtl/proc_mem_arbiter.sv
// Shares one memory port between TinyRV1 fetch and data ports; an in-order tag FIFO routes responses back.
// Define PROC_MEM_ARB_RR_EN for round-robin contention; otherwise dmem has fixed priority.
module proc_mem_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  output logic        imemreq_rdy,
  input  logic [31:0] imemreq_addr,
  output logic        imemresp_val,
  output logic [31:0] imemresp_data,
  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic        dmemresp_val,
  output logic [31:0] dmemresp_data,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  output logic        memreq_type,
  output logic [31:0] memreq_addr,
  output logic [31:0] memreq_wdata,
  input  logic        memresp_val,
  input  logic [31:0] memresp_data,
  output logic        err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] r_tags;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_err;

  logic w_full;
  logic w_any;
  logic w_gnt_d;
  logic w_fire;
  logic w_pop;
  logic w_drop;
  logic w_head_tag;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_any  = imemreq_val | dmemreq_val;

  // Winner select: w_gnt_d=1 means the data port owns the shared request this cycle
`ifdef PROC_MEM_ARB_RR_EN
  logic r_last_d;

  always_comb begin
    w_gnt_d = dmemreq_val;
    if (imemreq_val && dmemreq_val) begin
      w_gnt_d = !r_last_d;
    end
  end
`else
  always_comb begin
    w_gnt_d = dmemreq_val;
  end
`endif

  // Request path: winner drives the shared port; idle drives zeros
  always_comb begin
    memreq_val   = !rst && !w_full && w_any;
    memreq_type  = 1'b0;
    memreq_addr  = 32'h0;
    memreq_wdata = 32'h0;
    if (w_any) begin
      if (w_gnt_d) begin
        memreq_type  = dmemreq_type;
        memreq_addr  = dmemreq_addr;
        memreq_wdata = dmemreq_wdata;
      end else begin
        memreq_addr  = imemreq_addr;
      end
    end
  end

  assign dmemreq_rdy = !rst && !w_full && memreq_rdy && w_gnt_d;
  assign imemreq_rdy = !rst && !w_full && memreq_rdy && imemreq_val && !w_gnt_d;

  assign w_fire = memreq_val && memreq_rdy;

  // Response path: head tag steers memresp to its issuer with no added latency
  assign w_head_tag    = r_tags[r_head];
  assign w_pop         = !rst && memresp_val && (r_count != '0);
  assign w_drop        = memresp_val && (r_count == '0);
  assign imemresp_val  = w_pop && !w_head_tag;
  assign dmemresp_val  = w_pop &&  w_head_tag;
  assign imemresp_data = memresp_data;
  assign dmemresp_data = memresp_data;
  assign err           = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tags  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_fire) begin
        r_tags[r_tail] <= w_gnt_d;
        r_tail         <= (r_tail == PW'(DEPTH - 1)) ? '0 : r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= (r_head == PW'(DEPTH - 1)) ? '0 : r_head + PW'(1);
      end
      if (w_fire && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_fire && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef PROC_MEM_ARB_RR_EN
  // Last-grant starts at imem so the first contention after reset goes to dmem
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (w_fire) begin
      r_last_d <= w_gnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Directed bench for proc_mem_arbiter (DEPTH=2); expected values are hand-computed per step.
module tb_proc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;
  logic        dmemreq_val;
  logic        dmemreq_rdy;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic        dmemresp_val;
  logic [31:0] dmemresp_data;
  logic        memreq_val;
  logic        memreq_rdy;
  logic        memreq_type;
  logic [31:0] memreq_addr;
  logic [31:0] memreq_wdata;
  logic        memresp_val;
  logic [31:0] memresp_data;
  logic        err;

  int n_err    = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  proc_mem_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_addr(imemreq_addr),
    .imemresp_val(imemresp_val), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_type(dmemreq_type),
    .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
    .dmemresp_val(dmemresp_val), .dmemresp_data(dmemresp_data),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
    .memreq_addr(memreq_addr), .memreq_wdata(memreq_wdata),
    .memresp_val(memresp_val), .memresp_data(memresp_data),
    .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // Reset with every input active: all val/rdy outputs must be gated off
    rst = 1'b1; imemreq_val = 1'b1; imemreq_addr = 32'h0;
    dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'h0; dmemreq_wdata = 32'h0;
    memreq_rdy = 1'b1; memresp_val = 1'b1; memresp_data = 32'h0;
    settle();
    chk("rst_memreq_val", 32'(memreq_val), 32'd0);
    chk("rst_imemreq_rdy", 32'(imemreq_rdy), 32'd0);
    chk("rst_dmemreq_rdy", 32'(dmemreq_rdy), 32'd0);
    chk("rst_imemresp_val", 32'(imemresp_val), 32'd0);
    chk("rst_dmemresp_val", 32'(dmemresp_val), 32'd0);
    tick(); tick();
    chk("rst_err", 32'(err), 32'd0);
    imemreq_val = 1'b0; dmemreq_val = 1'b0; memresp_val = 1'b0;
    rst = 1'b0;
    settle();
    chk("idle_memreq_val", 32'(memreq_val), 32'd0);
    chk("idle_memreq_addr", memreq_addr, 32'h0);
    chk("idle_err", 32'(err), 32'd0);

    // Fetch only: two reads fill the FIFO, third blocks until a response pops
    imemreq_val = 1'b1; imemreq_addr = 32'h0;
    settle();
    chk("f0_memreq_val", 32'(memreq_val), 32'd1);
    chk("f0_imemreq_rdy", 32'(imemreq_rdy), 32'd1);
    chk("f0_memreq_addr", memreq_addr, 32'h0);
    chk("f0_memreq_type", 32'(memreq_type), 32'd0);
    tick();
    imemreq_addr = 32'h4;
    settle();
    chk("f1_imemreq_rdy", 32'(imemreq_rdy), 32'd1);
    chk("f1_memreq_addr", memreq_addr, 32'h4);
    tick();
    imemreq_addr = 32'h8;
    settle();
    chk("f2_full_rdy", 32'(imemreq_rdy), 32'd0);
    chk("f2_full_val", 32'(memreq_val), 32'd0);
    tick();
    memresp_val = 1'b1; memresp_data = 32'h00000013;
    settle();
    chk("f3_imemresp_val", 32'(imemresp_val), 32'd1);
    chk("f3_imemresp_data", imemresp_data, 32'h00000013);
    chk("f3_dmemresp_val", 32'(dmemresp_val), 32'd0);
    chk("f3_pop_no_unblock", 32'(imemreq_rdy), 32'd0);
    tick();
    memresp_data = 32'h00000017;
    settle();
    chk("f4_rdy_after_pop", 32'(imemreq_rdy), 32'd1);
    chk("f4_imemresp_val", 32'(imemresp_val), 32'd1);
    chk("f4_imemresp_data", imemresp_data, 32'h00000017);
    tick();
    imemreq_val = 1'b0; memresp_data = 32'h0000001B;
    settle();
    chk("f5_imemresp_val", 32'(imemresp_val), 32'd1);
    tick();
    memresp_val = 1'b0;
    settle();
    chk("f6_drained_err", 32'(err), 32'd0);

`ifndef PROC_MEM_ARB_RR_EN
    // Fixed priority contention: dmem wins every cycle
    imemreq_val = 1'b1; imemreq_addr = 32'h20;
    dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'h200;
    for (int i = 0; i < 3; i++) begin
      memresp_val = (i != 0);
      memresp_data = 32'h1000 + 32'(i);
      settle();
      chk("c_dmemreq_rdy", 32'(dmemreq_rdy), 32'd1);
      chk("c_imemreq_rdy", 32'(imemreq_rdy), 32'd0);
      chk("c_memreq_addr", memreq_addr, 32'h200);
      if (i != 0) begin
        chk("c_dmemresp_val", 32'(dmemresp_val), 32'd1);
        chk("c_imemresp_val", 32'(imemresp_val), 32'd0);
      end
      tick();
    end
    imemreq_val = 1'b0; dmemreq_val = 1'b0; memresp_val = 1'b1;
    settle();
    chk("c_last_dmemresp", 32'(dmemresp_val), 32'd1);
    tick();
    memresp_val = 1'b0;
`else
    // Round-robin contention: grants alternate dmem, imem, dmem, imem
    imemreq_val = 1'b1; imemreq_addr = 32'h20;
    dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      memresp_val = (i != 0);
      settle();
      chk("rr_dmemreq_rdy", 32'(dmemreq_rdy), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_imemreq_rdy", 32'(imemreq_rdy), (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i != 0) begin
        chk("rr_dmemresp_val", 32'(dmemresp_val), (i % 2 == 1) ? 32'd1 : 32'd0);
        chk("rr_imemresp_val", 32'(imemresp_val), (i % 2 == 1) ? 32'd0 : 32'd1);
      end
      tick();
    end
    imemreq_val = 1'b0; dmemreq_val = 1'b0; memresp_val = 1'b1;
    settle();
    chk("rr_last_imemresp", 32'(imemresp_val), 32'd1);
    tick();
    memresp_val = 1'b0;
`endif

    // Write path, then an imem read showing type/wdata forced to zero
    dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h100; dmemreq_wdata = 32'hDEADBEEF;
    settle();
    chk("w_memreq_type", 32'(memreq_type), 32'd1);
    chk("w_memreq_wdata", memreq_wdata, 32'hDEADBEEF);
    chk("w_memreq_addr", memreq_addr, 32'h100);
    chk("w_dmemreq_rdy", 32'(dmemreq_rdy), 32'd1);
    tick();
    dmemreq_val = 1'b0; imemreq_val = 1'b1; imemreq_addr = 32'h40;
    settle();
    chk("i_memreq_wdata", memreq_wdata, 32'h0);
    chk("i_memreq_type", 32'(memreq_type), 32'd0);
    chk("i_memreq_addr", memreq_addr, 32'h40);
    tick();
    imemreq_val = 1'b0; memresp_val = 1'b1; memresp_data = 32'h0;
    settle();
    chk("w_dmemresp_val", 32'(dmemresp_val), 32'd1);
    chk("w_imemresp_val0", 32'(imemresp_val), 32'd0);
    tick();
    memresp_data = 32'hCAFE0001;
    settle();
    chk("i_imemresp_val", 32'(imemresp_val), 32'd1);
    chk("i_dmemresp_data", dmemresp_data, 32'hCAFE0001);
    tick();
    memresp_val = 1'b0;

    // Memory stall: request visible but not accepted, nothing pushed
    imemreq_val = 1'b1; imemreq_addr = 32'h80; memreq_rdy = 1'b0;
    settle();
    chk("s_memreq_val", 32'(memreq_val), 32'd1);
    chk("s_imemreq_rdy", 32'(imemreq_rdy), 32'd0);
    tick();
    memreq_rdy = 1'b1;

    // Full with simultaneous response: no fire that cycle, fires the next
    imemreq_addr = 32'hA0;
    tick();
    imemreq_addr = 32'hA4;
    tick();
    imemreq_val = 1'b0;
    dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'h300; memresp_val = 1'b1;
    settle();
    chk("full_memreq_val", 32'(memreq_val), 32'd0);
    chk("full_dmemreq_rdy", 32'(dmemreq_rdy), 32'd0);
    chk("full_imemresp_val", 32'(imemresp_val), 32'd1);
    tick();
    memresp_val = 1'b0;
    settle();
    chk("full_next_rdy", 32'(dmemreq_rdy), 32'd1);
    chk("full_next_val", 32'(memreq_val), 32'd1);
    tick();
    dmemreq_val = 1'b0; memresp_val = 1'b1;
    settle();
    chk("full_drain_imem", 32'(imemresp_val), 32'd1);
    tick();
    settle();
    chk("full_drain_dmem", 32'(dmemresp_val), 32'd1);
    tick();

    // Response with empty FIFO: dropped and err sticks until reset
    settle();
    chk("e_imemresp_val", 32'(imemresp_val), 32'd0);
    chk("e_dmemresp_val", 32'(dmemresp_val), 32'd0);
    tick();
    memresp_val = 1'b0;
    chk("e_err_set", 32'(err), 32'd1);
    tick(); tick();
    chk("e_err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("e_err_cleared", 32'(err), 32'd0);

    // Reset mid-flight discards the outstanding tag
    imemreq_val = 1'b1; imemreq_addr = 32'hC0;
    tick();
    imemreq_val = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; memresp_val = 1'b1;
    settle();
    chk("r_imemresp_dropped", 32'(imemresp_val), 32'd0);
    tick();
    memresp_val = 1'b0;
    chk("r_err_after_reset", 32'(err), 32'd1);
    settle();
    chk("r_count_zero_rdy", 32'(imemreq_rdy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
